// File: rtl/rpn_pkg.sv
// rtl/rpn_pkg.sv - shared constants, state types and power-of-ten table for the RPN UART computer
package rpn_pkg;

    localparam int DEFAULT_CLKS_PER_BIT = 1085;
    localparam int BUF_DEPTH            = 7;
    localparam int NUM_POWERS           = 5;

    localparam logic [7:0] CH_MINUS = 8'h2D;
    localparam logic [7:0] CH_ZERO  = 8'h30;
    localparam logic [7:0] CH_E     = 8'h45;
    localparam logic [7:0] CH_LF    = 8'h0A;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOADERR,
        ST_CONV,
        ST_TERM,
        ST_SEND
    } tx_state_t;

    typedef enum logic [1:0] {
        BT_IDLE,
        BT_START,
        BT_DATA,
        BT_STOP
    } byte_state_t;

    function automatic logic [15:0] pow10(input logic [2:0] idx);
        case (idx)
            3'd0:    return 16'd10000;
            3'd1:    return 16'd1000;
            3'd2:    return 16'd100;
            3'd3:    return 16'd10;
            default: return 16'd1;
        endcase
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// rtl/uart_tx_byte.sv - 8N1 byte serializer with registered tx and back-to-back chaining
module uart_tx_byte
    import rpn_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data,
    input  logic       start,
    output logic       tx,
    output logic       done
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    byte_state_t   state, state_next;
    logic [CW-1:0] baud_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          tick;
    logic          load;

    assign tick = (baud_cnt == CW'(CLKS_PER_BIT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= BT_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            BT_IDLE:  if (start) state_next = BT_START;
            BT_START: if (tick) state_next = BT_DATA;
            BT_DATA:  if (tick && bit_idx == 3'd7) state_next = BT_STOP;
            BT_STOP:  if (tick) state_next = start ? BT_START : BT_IDLE;
            default:  state_next = BT_IDLE;
        endcase
    end

    // A start seen in the done cycle reloads immediately, so the next start bit has no gap.
    always_comb begin
        done = (state == BT_STOP) && tick;
        load = start && ((state == BT_IDLE) || done);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            baud_cnt <= '0;
            bit_idx  <= 3'd0;
            shreg    <= 8'd0;
            tx       <= 1'b1;
        end else if (load) begin
            baud_cnt <= '0;
            bit_idx  <= 3'd0;
            shreg    <= data;
            tx       <= 1'b0;
        end else if (state != BT_IDLE) begin
            baud_cnt <= tick ? '0 : baud_cnt + 1'b1;
            if (tick) begin
                case (state)
                    BT_START: tx <= shreg[0];
                    BT_DATA: begin
                        if (bit_idx == 3'd7) begin
                            tx <= 1'b1;
                        end else begin
                            tx      <= shreg[1];
                            shreg   <= {1'b0, shreg[7:1]};
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end
                    default: tx <= 1'b1;
                endcase
            end
        end
    end

endmodule

// File: rtl/rpn_result_tx.sv
// rtl/rpn_result_tx.sv - converts a signed 16-bit result to a decimal ASCII line and sends it over UART
module rpn_result_tx
    import rpn_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        result_valid,
    output logic        result_ready,
    input  logic [15:0] result,
    input  logic        result_err,
    output logic        tx,
    output logic        busy
);

    tx_state_t   state, state_next;
    logic [15:0] mag;
    logic [2:0]  pow_idx;
    logic [3:0]  digit;
    logic        started;
    logic [7:0]  line_buf [0:BUF_DEPTH-1];
    logic [2:0]  len;
    logic [2:0]  send_idx;
    logic        kick;

    logic        take;
    logic [15:0] pow;
    logic        mag_ge;
    logic        last_pow;
    logic        store_digit;
    logic        last_byte;
    logic        byte_start;
    logic        byte_done;
    logic [7:0]  byte_data;
    logic [2:0]  sel;

    assign take        = result_valid && result_ready;
    assign pow         = pow10(pow_idx);
    assign mag_ge      = (mag >= pow);
    assign last_pow    = (pow_idx == 3'(NUM_POWERS - 1));
    assign store_digit = started || (digit != 4'd0) || last_pow;
    assign last_byte   = (send_idx == len - 3'd1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:    if (take) state_next = result_err ? ST_LOADERR : ST_CONV;
            ST_LOADERR: state_next = ST_TERM;
            ST_CONV:    if (!mag_ge && last_pow) state_next = ST_TERM;
            ST_TERM:    state_next = ST_SEND;
            ST_SEND:    if (byte_done && last_byte) state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

    // kick launches the first byte; later bytes chain off the serializer's done pulse.
    always_comb begin
        result_ready = (state == ST_IDLE);
        busy         = (state != ST_IDLE);
        byte_start   = (state == ST_SEND) && (kick || (byte_done && !last_byte));
        sel          = kick ? send_idx : send_idx + 3'd1;
        byte_data    = (sel < 3'(BUF_DEPTH)) ? line_buf[sel] : CH_LF;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mag      <= 16'd0;
            pow_idx  <= 3'd0;
            digit    <= 4'd0;
            started  <= 1'b0;
            len      <= 3'd0;
            send_idx <= 3'd0;
            kick     <= 1'b0;
            for (int i = 0; i < BUF_DEPTH; i++) line_buf[i] <= 8'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (take) begin
                        pow_idx  <= 3'd0;
                        digit    <= 4'd0;
                        started  <= 1'b0;
                        send_idx <= 3'd0;
                        if (!result_err && result[15]) begin
                            line_buf[0] <= CH_MINUS;
                            len         <= 3'd1;
                            mag         <= 16'd0 - result;
                        end else begin
                            len <= 3'd0;
                            mag <= result;
                        end
                    end
                end
                ST_LOADERR: begin
                    line_buf[len] <= CH_E;
                    len           <= len + 3'd1;
                end
                ST_CONV: begin
                    if (mag_ge) begin
                        mag   <= mag - pow;
                        digit <= digit + 4'd1;
                    end else begin
                        if (store_digit) begin
                            line_buf[len] <= CH_ZERO + {4'd0, digit};
                            len           <= len + 3'd1;
                        end
                        if (digit != 4'd0) started <= 1'b1;
                        digit   <= 4'd0;
                        pow_idx <= pow_idx + 3'd1;
                    end
                end
                ST_TERM: begin
                    line_buf[len] <= CH_LF;
                    len           <= len + 3'd1;
                    kick          <= 1'b1;
                end
                ST_SEND: begin
                    kick <= 1'b0;
                    if (byte_start && !kick) send_idx <= send_idx + 3'd1;
                end
                default: ;
            endcase
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_byte (
        .clk   (clk),
        .rst   (rst),
        .data  (byte_data),
        .start (byte_start),
        .tx    (tx),
        .done  (byte_done)
    );

endmodule

// File: tb/tb_rpn_result_tx.sv
// tb/tb_rpn_result_tx.sv - directed self-checking bench for rpn_result_tx with a UART line monitor
module tb_rpn_result_tx;

    localparam int CPB = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        result_valid = 1'b0;
    logic        result_err = 1'b0;
    logic [15:0] result = 16'd0;
    logic        result_ready;
    logic        tx;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [7:0] rx_q[$];
    int         rx_t[$];

    rpn_result_tx #(
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .result       (result),
        .result_err   (result_err),
        .tx           (tx),
        .busy         (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s.%s: observed 0x%0h expected 0x%0h", tag, name, obs, exp);
        end
    endtask

    // Samples each bit at its mid-point; cyc at detection is the posedge that began the start bit.
    initial begin : uart_mon
        logic [7:0] b;
        int         t0;
        forever begin
            @(negedge clk);
            if (!rst && tx === 1'b0) begin
                t0 = cyc;
                repeat (CPB / 2 - 1) @(negedge clk);
                check("mon", "start_bit", {31'd0, tx}, 32'd0);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    b[i] = tx;
                end
                repeat (CPB) @(negedge clk);
                check("mon", "stop_bit", {31'd0, tx}, 32'd1);
                rx_q.push_back(b);
                rx_t.push_back(t0);
            end
        end
    end

    task automatic run_line(input string tag, input logic [15:0] v, input logic e,
                            input string exp, input bit hold);
        int x;
        int t_rdy;
        bit got;
        rx_q.delete();
        rx_t.delete();
        @(negedge clk);
        check(tag, "ready_before", {31'd0, result_ready}, 32'd1);
        result       = v;
        result_err   = e;
        result_valid = 1'b1;
        x            = cyc + 1;
        @(negedge clk);
        check(tag, "ready_fall", {31'd0, result_ready}, 32'd0);
        check(tag, "busy_rise", {31'd0, busy}, 32'd1);
        if (hold) begin
            result     = v ^ 16'h5A5A;
            result_err = 1'b0;
        end else begin
            result_valid = 1'b0;
        end
        got   = 1'b0;
        t_rdy = 0;
        for (int n = 0; n < 2000 && !got; n++) begin
            @(negedge clk);
            if (result_ready === 1'b1) begin
                got   = 1'b1;
                t_rdy = cyc;
            end
        end
        result_valid = 1'b0;
        check(tag, "line_done", {31'd0, got}, 32'd1);
        check(tag, "byte_count", rx_q.size(), exp.len());
        for (int i = 0; i < exp.len() && i < rx_q.size(); i++)
            check(tag, $sformatf("byte%0d", i), {24'd0, rx_q[i]}, {24'd0, exp[i]});
        if (rx_t.size() > 0) begin
            check(tag, "first_start_le55", {31'd0, (rx_t[0] - x) <= 55}, 32'd1);
            for (int i = 1; i < rx_t.size(); i++)
                check(tag, $sformatf("gap%0d", i), rx_t[i] - rx_t[i-1], 10 * CPB);
            check(tag, "ready_return", t_rdy, rx_t[rx_t.size()-1] + 10 * CPB);
        end
        check(tag, "busy_low", {31'd0, busy}, 32'd0);
    endtask

    initial begin : stim
        bit got;
        int n_before;

        repeat (3) @(negedge clk);
        check("reset", "tx", {31'd0, tx}, 32'd1);
        check("reset", "ready", {31'd0, result_ready}, 32'd1);
        check("reset", "busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("post_reset", "tx", {31'd0, tx}, 32'd1);

        run_line("r36", 16'd36, 1'b0, "36\n", 1'b0);
        run_line("r0", 16'd0, 1'b0, "0\n", 1'b0);
        run_line("r10000", 16'd10000, 1'b0, "10000\n", 1'b0);
        run_line("rmin", 16'h8000, 1'b0, "-32768\n", 1'b0);
        run_line("rm1", 16'hFFFF, 1'b0, "-1\n", 1'b0);
        run_line("rerr", 16'd123, 1'b1, "E\n", 1'b0);

        run_line("hold", 16'd36, 1'b0, "36\n", 1'b1);
        n_before = rx_q.size();
        repeat (40) @(negedge clk);
        check("hold", "no_extra_busy", {31'd0, busy}, 32'd0);
        check("hold", "no_extra_bytes", rx_q.size(), n_before);

        rx_q.delete();
        rx_t.delete();
        @(negedge clk);
        result       = 16'd12;
        result_err   = 1'b0;
        result_valid = 1'b1;
        @(negedge clk);
        result_valid = 1'b0;
        got = 1'b0;
        for (int n = 0; n < 200 && !got; n++) begin
            @(negedge clk);
            if (tx === 1'b0) got = 1'b1;
        end
        check("rst_mid", "start_seen", {31'd0, got}, 32'd1);
        repeat (19) @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_mid", "tx", {31'd0, tx}, 32'd1);
        check("rst_mid", "ready", {31'd0, result_ready}, 32'd1);
        check("rst_mid", "busy", {31'd0, busy}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (100) @(negedge clk);
        check("rst_mid", "tx_idle", {31'd0, tx}, 32'd1);
        run_line("r7", 16'd7, 1'b0, "7\n", 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
